// File: rtl/demux_lane_scheduler_if.sv
// Stream-in / lane-out bundle for the 4-way pixel demux sequencer.
// Handshake: a beat moves on a rising edge where valid and ready are both high; valid, data and last
// hold steady until that edge, and ready never depends combinationally on valid.
interface demux_lane_scheduler_if #(
  parameter int bits = 8
);
  logic            in_valid;
  logic [bits-1:0] in_data;
  logic            in_last;
  logic            in_ready;
  logic [3:0]      lane_ready;
  logic [1:0]      sel;
  logic [bits-1:0] out_data;
  logic [3:0]      out_valid;

  modport master (
    input  in_valid, in_data, in_last, lane_ready,
    output in_ready, sel, out_data, out_valid
  );

  modport slave (
    output in_valid, in_data, in_last, lane_ready,
    input  in_ready, sel, out_data, out_valid
  );
endinterface

// File: rtl/demux_lane_scheduler.sv
// Round-robin burst sequencer for the 4-way pixel demux: one output register and per-lane backpressure.
// Lanes can be masked out, and in_last cuts a burst short.
module demux_lane_scheduler #(
  parameter int bits      = 8,
  parameter int burst_len = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            lane_mask,
  demux_lane_scheduler_if.master bus,
  output logic                  busy,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [15:0] last_cnt = 16'(burst_len - 1);

  state_t          state_q, state_d;
  logic [1:0]      cur_q;
  logic [15:0]     cnt_q;
  logic            ovalid_q;
  logic [1:0]      sel_q;
  logic [bits-1:0] data_q;

  logic in_ready_c;
  logic busy_c;
  logic transfer;
  logic accept;
  logic start;

  // First set mask bit after c, wrapping around; c itself is the last resort.
  function automatic logic [1:0] next_lane(input logic [1:0] c, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    r = c;
    for (int k = 3; k >= 1; k--) begin
      idx = c + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = 2'(k);
    end
    return r;
  endfunction

  assign transfer = ovalid_q && bus.lane_ready[sel_q];
  assign accept   = bus.in_valid && in_ready_c;
  assign start    = (state_q == IDLE) && (state_d == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && (lane_mask != 4'd0)) state_d = ACTIVE;
      ACTIVE:  if (!enable || (lane_mask == 4'd0)) state_d = DRAIN;
      DRAIN:   if (!ovalid_q || transfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = (state_q != IDLE);
    if (state_q == ACTIVE) in_ready_c = !ovalid_q || bus.lane_ready[sel_q];
  end

  // Lane/count bookkeeping and the single-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q    <= 2'd0;
      cnt_q    <= 16'd0;
      ovalid_q <= 1'b0;
      sel_q    <= 2'd0;
      data_q   <= '0;
    end else begin
      if (start) begin
        cur_q <= lowest_lane(lane_mask);
        cnt_q <= 16'd0;
      end
      if (accept) begin
        data_q   <= bus.in_data;
        sel_q    <= cur_q;
        ovalid_q <= 1'b1;
        if ((cnt_q == last_cnt) || bus.in_last) begin
          cnt_q <= 16'd0;
          cur_q <= next_lane(cur_q, lane_mask);
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end else if (transfer) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = ovalid_q ? (4'b0001 << sel_q) : 4'b0000;
  assign busy          = busy_c;
  assign state         = state_q;

endmodule
